// File: rtl/sample_packer_if.sv
// Sample-in / packed-word-out bus for the error-matrix packer.
// The control side drives start/level/samples; the packer drives status and writes.
interface sample_packer_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [1:0]        level;
    logic [7:0]        sample_in;
    logic              sample_valid;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic              done;
    logic              err;

    modport master (
        output start, level, sample_in, sample_valid,
        input  busy, wr_en, wr_addr, wr_data, done, err
    );

    modport slave (
        input  start, level, sample_in, sample_valid,
        output busy, wr_en, wr_addr, wr_data, done, err
    );
endinterface

// File: rtl/sample_packer.sv
// Packs Gaussian error samples into 64-bit words of four 16-bit coefficients
// and writes one Frodo error matrix (N x 8 samples) to memory per start.
module sample_packer #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input logic          clk,
    input logic          rst_n,
    sample_packer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lvl;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] words;
    logic [ADDR_W-1:0] total;
    logic [47:0]       part;
    logic [15:0]       coef;
    logic              take;

    always_comb begin
        total = '0;
        unique case (1'b1)
            lvl == 2'b01: total = ADDR_W'(2688);
            lvl == 2'b10: total = ADDR_W'(1952);
            lvl == 2'b11: total = ADDR_W'(1280);
            default:      total = '0;
        endcase
    end

    // Level 11 works mod 2^15, so the sign-extended top bit is dropped.
    always_comb begin
        coef = {{8{bus.sample_in[7]}}, bus.sample_in};
        if (lvl == 2'b11) coef[15] = 1'b0;
    end

    assign take = (state == RUN) && bus.sample_valid && (words != total);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && bus.level != 2'b00) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (bus.wr_en && words == total) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lvl         <= 2'b00;
            lane        <= 2'd0;
            words       <= '0;
            part        <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.err     <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.err   <= 1'b0;
            if (state == IDLE && bus.start) begin
                if (bus.level == 2'b00) begin
                    bus.err <= 1'b1;
                end else begin
                    lvl   <= bus.level;
                    lane  <= 2'd0;
                    words <= '0;
                    part  <= '0;
                end
            end
            if (take) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0: part[15:0]  <= coef;
                    2'd1: part[31:16] <= coef;
                    2'd2: part[47:32] <= coef;
                    2'd3: begin
                        bus.wr_data <= {coef, part};
                        bus.wr_addr <= ADDR_W'(BASE_ADDR) + words;
                        bus.wr_en   <= 1'b1;
                        words       <= words + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// Randomized bench for sample_packer against a cycle-level reference model
// built from coefficient queues and sample/word counts.
module tb_sample_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    sample_packer_if #(.ADDR_W(12)) bus ();

    sample_packer #(
        .ADDR_W   (12),
        .BASE_ADDR(0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int phase = 0;
    int acc = 0;
    int total = 0;
    int nwr = 0;
    bit last_wr = 1'b0;
    logic [1:0] mlvl = 2'b00;
    int q[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int coef_of(input logic [7:0] s, input logic [1:0] l);
        int c;
        c = int'($signed(s));
        if (c < 0) c += 65536;
        if (l == 2'b11) c = c % 32768;
        return c;
    endfunction

    function automatic int words_of(input logic [1:0] l);
        case (l)
            2'b01:   return 1344 * 8 / 4;
            2'b10:   return 976 * 8 / 4;
            2'b11:   return 640 * 8 / 4;
            default: return 0;
        endcase
    endfunction

    task automatic cyc(input bit st, input logic [1:0] lv,
                       input bit v, input logic [7:0] s);
        bit acc_now;
        bit wr_exp;
        bit err_exp;
        int nphase;
        logic [63:0] w;
        bus.start        = st;
        bus.level        = lv;
        bus.sample_valid = v;
        bus.sample_in    = s;
        acc_now = (phase == 1) && v && (acc < total);
        err_exp = (phase == 0) && st && (lv == 2'b00);
        wr_exp  = 1'b0;
        nphase  = phase;
        case (phase)
            0: if (st && lv != 2'b00) begin
                nphase = 1;
                mlvl   = lv;
                acc    = 0;
                nwr    = 0;
                total  = words_of(lv) * 4;
                q.delete();
            end
            1: if (last_wr) nphase = 2;
            default: nphase = 0;
        endcase
        if (acc_now) begin
            q.push_back(coef_of(s, mlvl));
            acc++;
            wr_exp = (acc % 4 == 0);
        end
        last_wr = wr_exp && (acc == total);
        @(posedge clk);
        #1;
        phase = nphase;
        chk("wr_en", 64'(bus.wr_en), 64'(wr_exp));
        chk("busy", 64'(bus.busy), 64'(phase == 1));
        chk("done", 64'(bus.done), 64'(phase == 2));
        chk("err", 64'(bus.err), 64'(err_exp));
        if (bus.wr_en) begin
            if (q.size() < 4) begin
                chk("queue_depth", 64'(q.size()), 64'd4);
            end else begin
                w = '0;
                for (int k = 0; k < 4; k++) w[16*k +: 16] = 16'(q.pop_front());
                chk("wr_data", bus.wr_data, w);
                chk("wr_addr", 64'(bus.wr_addr), 64'(nwr));
            end
            nwr++;
        end
    endtask

    task automatic reset_dut();
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", bus.wr_data, 64'd0);
        phase   = 0;
        acc     = 0;
        total   = 0;
        nwr     = 0;
        last_wr = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    task automatic fill(input logic [1:0] lv, input int gap);
        int n;
        bit st;
        cyc(1'b1, lv, 1'b0, 8'h00);
        n = 0;
        while (phase != 0 && n < 40000) begin
            st = ($urandom_range(49) == 0);
            cyc(st, 2'($urandom_range(3)), $urandom_range(99) >= gap,
                8'($urandom_range(255)));
            n++;
        end
        chk("fill_timeout", 64'(phase != 0), 64'd0);
        chk("nwrites", 64'(nwr), 64'(words_of(lv)));
        for (int i = 0; i < 8; i++)
            cyc(1'b0, lv, 1'b1, 8'($urandom_range(255)));
    endtask

    logic [7:0] pat [4];

    initial begin
        bus.start        = 1'b0;
        bus.level        = 2'b00;
        bus.sample_in    = 8'h00;
        bus.sample_valid = 1'b0;
        pat[0] = 8'h01;
        pat[1] = 8'hFF;
        pat[2] = 8'h02;
        pat[3] = 8'hF3;
        @(posedge clk);
        reset_dut();

        cyc(1'b1, 2'b11, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 1'b1, pat[i]);
        chk("l11_word", bus.wr_data, 64'h7FF3_0002_7FFF_0001);
        chk("l11_addr", 64'(bus.wr_addr), 64'd0);
        reset_dut();

        cyc(1'b1, 2'b10, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 1'b1, pat[i]);
        chk("l10_word", bus.wr_data, 64'hFFF3_0002_FFFF_0001);
        chk("l10_addr", 64'(bus.wr_addr), 64'd0);
        reset_dut();

        cyc(1'b1, 2'b00, 1'b1, 8'h55);
        chk("err_pulse", 64'(bus.err), 64'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b1, 8'h55);

        cyc(1'b1, 2'b10, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'b10, 1'b1, 8'(i + 8'h10));
        reset_dut();
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b10, 1'b1, 8'h77);
        cyc(1'b1, 2'b01, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01, 1'b1, 8'(8'hA0 + i));
        chk("restart_wr_en", 64'(bus.wr_en), 64'd1);
        chk("restart_addr", 64'(bus.wr_addr), 64'd0);
        chk("restart_word", bus.wr_data, 64'hFFA3_FFA2_FFA1_FFA0);
        reset_dut();

        fill(2'b11, 30);
        fill(2'b01, 0);
        fill(2'b10, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the wr_addr width in bits (covers 2688 words).
REQ-002 SHALL have parameter BASE_ADDR, default 0, giving the word address of the first write.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a matrix fill.
REQ-006 SHALL have port level, input, 2 bits: security level (01=Frodo-1344, 10=Frodo-976, 11=Frodo-640, 00=invalid).
REQ-007 SHALL have port sample_in, input, 8 bits: two's-complement error sample from the Gaussian sampler.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample_in is valid this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a fill is in progress.
REQ-010 SHALL have port wr_en, output, 1 bit: single-cycle memory write strobe.
REQ-011 SHALL have port wr_addr, output, ADDR_W bits: memory word address.
REQ-012 SHALL have port wr_data, output, 64 bits: four packed 16-bit coefficients.
REQ-013 SHALL have port done, output, 1 bit: single-cycle pulse when the fill completes.
REQ-014 SHALL have port err, output, 1 bit: single-cycle pulse when start arrives with level 00.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 IDLE: start with level≠00 SHALL latch level, clear the sample and word counters, and go to RUN; busy=1 from the next cycle.
REQ-017 IDLE: start with level=00 SHALL pulse err the next cycle and remain in IDLE.
REQ-018 Total sample count SHALL be N×8, with N=1344/976/640 for level 01/10/11, i.e. 10752/7808/5120 samples = 2688/1952/1280 words.
REQ-019 RUN: each cycle with sample_valid=1 SHALL accept exactly one sample; cycles with sample_valid=0 SHALL leave all state unchanged.
REQ-020 Coefficient conversion SHALL sign-extend sample_in to 16 bits, then for level 11 force bit 15 to 0 (mod 2^15); levels 01/10 SHALL keep all 16 bits (mod 2^16).
REQ-021 Packing order: 1st accepted sample of a word in wr_data[15:0], 2nd in [31:16], 3rd in [47:32], 4th in [63:48].
REQ-022 The cycle after the 4th sample of a word is accepted, the block SHALL drive wr_en=1 with the full word on wr_data and wr_addr=BASE_ADDR+word index.
REQ-023 wr_en SHALL be high for exactly one cycle per word; wr_addr and wr_data SHALL hold their values until the next write.
REQ-024 A sample accepted in the same cycle as a wr_en SHALL go into lane 0 of the next word without loss (back-to-back valid supported).
REQ-025 After the last word is written, the FSM SHALL go to DONE, drop busy, and accept no further samples.
REQ-026 DONE SHALL pulse done for one cycle, in the cycle after the final wr_en, then return to IDLE.
REQ-027 sample_valid outside RUN SHALL be ignored.
REQ-028 start while in RUN or DONE SHALL be ignored, and a level change mid-fill SHALL have no effect.
REQ-029 Word index arithmetic SHALL be unsigned with no wrap within a fill; the maximum index is 2687.

Reset
REQ-030 rst_n=1 at any time, including mid-fill, SHALL immediately force IDLE, clear the counters and the partial word, and drive busy, wr_en, done, err, wr_addr and wr_data to 0.
REQ-031 A partial word discarded by reset SHALL never be written.

Verification
REQ-032 Level 11, start, samples 0x01, 0xFF, 0x02, 0xF3 on consecutive cycles -> one cycle later wr_en=1, wr_addr=0, wr_data=64'h7FF3_0002_7FFF_0001.
REQ-033 Level 10, same four samples -> wr_data=64'hFFF3_0002_FFFF_0001, wr_addr=0.
REQ-034 Level 11 full fill, 5120 samples with random valid gaps -> 1280 writes at addresses 0..1279 in order, done one cycle after the write at 1279, busy low afterwards, extra samples ignored.
REQ-035 Level 01 continuous valid -> 2688 writes at addresses 0..2687 with no lost sample.
REQ-036 start with level=00 -> err pulse, busy stays 0, no wr_en.
REQ-037 Reset asserted after 6 samples -> all outputs 0 with no write of the partial word; a new start then writes its first word at wr_addr=0.
